// File: rtl/sevenseg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_decoder
// Brief    : Recovers a 4-digit BCD frame from a multiplexed, active-low
//            7-segment anode/segment drive.
// Revision : 1.0  initial release
// ============================================================================
module sevenseg_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic        msclk,
    input  logic        RST,
    input  logic [3:0]  an_in,
    input  logic [7:0]  seg_in,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        err,
    output logic        active
);

    localparam int                  c_IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT);
    localparam logic [3:0]          c_CNT_MAX  = 4'(SETTLE);
    localparam logic [3:0]          c_CNT_PRE  = 4'(SETTLE - 1);
    localparam logic [11:0]         c_PIN_IDLE = {4'b1111, 8'hFF};

    // Input synchronizer and history
    logic [11:0]         r_s1;
    logic [11:0]         r_s2;
    logic [11:0]         r_s3;
    logic [3:0]          r_cnt;

    // Frame assembly
    logic [15:0]         r_shadow;
    logic [3:0]          r_shadow_blank;
    logic [3:0]          r_shadow_dp;
    logic [3:0]          r_seen;

    // Delivered frame and status
    logic [15:0]         r_digits;
    logic [3:0]          r_blank;
    logic [3:0]          r_dp;
    logic                r_frame_valid;
    logic                r_err;
    logic [c_IDLE_W-1:0] r_idle;
    logic                r_delivered;

    logic                w_stable;
    logic                w_accept;
    logic [3:0]          w_an;
    logic [7:0]          w_seg;
    logic [3:0]          w_sel;
    logic                w_none;
    logic                w_onehot;
    logic                w_code_ok;
    logic                w_is_blank;
    logic [3:0]          w_value;
    logic                w_legal;
    logic                w_illegal;
    logic                w_frame_done;
    logic [3:0]          w_seen_base;

    assign w_stable     = (r_s2 == r_s3);
    assign w_accept     = w_stable && (r_cnt == c_CNT_PRE);
    assign w_an         = r_s3[11:8];
    assign w_seg        = r_s3[7:0];
    assign w_sel        = ~w_an;
    assign w_none       = (w_an == 4'b1111);
    assign w_onehot     = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
    assign w_legal      = w_accept && w_onehot && w_code_ok;
    assign w_illegal    = w_accept && !w_none && !(w_onehot && w_code_ok);
    assign w_frame_done = (r_seen == 4'b1111);
    // A completing frame frees all seen bits before this edge's accept lands
    assign w_seen_base  = w_frame_done ? 4'b0000 : r_seen;

    // Active-low segment pattern (g..a) to BCD value
    always_comb begin
        w_code_ok  = 1'b1;
        w_is_blank = 1'b0;
        w_value    = 4'd0;
        case (w_seg[6:0])
            7'h40:   w_value = 4'd0;
            7'h79:   w_value = 4'd1;
            7'h24:   w_value = 4'd2;
            7'h30:   w_value = 4'd3;
            7'h19:   w_value = 4'd4;
            7'h12:   w_value = 4'd5;
            7'h02:   w_value = 4'd6;
            7'h78:   w_value = 4'd7;
            7'h00:   w_value = 4'd8;
            7'h10:   w_value = 4'd9;
            7'h7F:   w_is_blank = 1'b1;
            default: w_code_ok = 1'b0;
        endcase
    end

    always_ff @(posedge msclk) begin
        if (RST) begin
            r_s1  <= c_PIN_IDLE;
            r_s2  <= c_PIN_IDLE;
            r_s3  <= c_PIN_IDLE;
            r_cnt <= 4'd0;
        end else begin
            r_s1 <= {an_in, seg_in};
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (!w_stable) begin
                r_cnt <= 4'd0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge msclk) begin
        if (RST) begin
            r_shadow       <= 16'h0000;
            r_shadow_blank <= 4'b0000;
            r_shadow_dp    <= 4'b0000;
            r_seen         <= 4'b0000;
            r_err          <= 1'b0;
        end else begin
            r_err <= w_illegal;
            if (w_illegal) begin
                r_seen <= 4'b0000;
            end else if (w_legal) begin
                r_seen <= w_seen_base | w_sel;
            end else begin
                r_seen <= w_seen_base;
            end
            for (int k = 0; k < 4; k++) begin
                if (w_legal && w_sel[k]) begin
                    r_shadow[4*k +: 4] <= w_is_blank ? 4'd0 : w_value;
                    r_shadow_blank[k]  <= w_is_blank;
                    r_shadow_dp[k]     <= ~w_seg[7];
                end
            end
        end
    end

    always_ff @(posedge msclk) begin
        if (RST) begin
            r_digits      <= 16'h0000;
            r_blank       <= 4'b1111;
            r_dp          <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_delivered   <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_digits    <= r_shadow;
                r_blank     <= r_shadow_blank;
                r_dp        <= r_shadow_dp;
                r_delivered <= 1'b1;
            end
        end
    end

    // Only accepted digit/blank codes count as activity, not blanking gaps
    always_ff @(posedge msclk) begin
        if (RST) begin
            r_idle <= '0;
        end else if (w_legal) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_MAX) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign digits      = r_digits;
    assign blank       = r_blank;
    assign dp          = r_dp;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;
    assign active      = r_delivered && (r_idle < c_IDLE_MAX);

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_decoder
// Brief    : Self-checking bench: table-driven frame scans with a frame
//            scoreboard, plus glitch, error, reset and timeout sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an_in = 4'b1111;
    logic [7:0]  seg_in = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        err;
    logic        active;

    typedef struct packed {
        logic [31:0] segs;
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  p;
    } frame_t;

    vec_t   vecs [4];
    frame_t exp_q [$];
    int     n_total = 0;
    int     n_pass  = 0;
    int     n_fv    = 0;
    int     n_err   = 0;

    sevenseg_decoder #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .msclk       (clk),
        .RST         (rst),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .digits      (digits),
        .blank       (blank),
        .dp          (dp),
        .frame_valid (frame_valid),
        .err         (err),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every frame_valid cycle must match the oldest expected frame
    always @(negedge clk) begin
        if (frame_valid) begin
            n_fv++;
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_digits", 32'(digits), 32'(f.d));
                check("frame_blank",  32'(blank),  32'(f.b));
                check("frame_dp",     32'(dp),     32'(f.p));
            end
        end
        if (err) n_err++;
    end

    task automatic show(input logic [3:0] an, input logic [7:0] seg, input int cycles);
        an_in  = an;
        seg_in = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scan_pos(input int k, input logic [7:0] seg);
        logic [3:0] one;
        one = 4'b0001 << k;
        show(~one, seg, 10);
    endtask

    task automatic push_frame(input vec_t v);
        exp_q.push_back({v.digits, v.blank, v.dp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0000);
        check({tag, "_blank"},  32'(blank),  32'hF);
        check({tag, "_dp"},     32'(dp),     32'h0);
        check({tag, "_active"}, 32'(active), 32'h0);
    endtask

    initial begin
        int     fv0;
        int     er0;
        int     lat;
        vec_t   v;

        vecs[0] = {32'hB0A4F9C0, 16'h3210, 4'b0000, 4'b0000};
        vecs[1] = {32'hB0FFF940, 16'h3010, 4'b0100, 4'b0001};
        vecs[2] = {32'h80F88292, 16'h8765, 4'b0000, 4'b0000};
        vecs[3] = {32'h197F9990, 16'h4049, 4'b0100, 4'b1100};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_fv",  32'(frame_valid), 32'h0);
        check("reset_err", 32'(err),         32'h0);
        rst = 1'b0;
        show(4'b1111, 8'hFF, 5);

        // Table-driven full-frame scans
        for (int i = 0; i < 4; i++) begin
            fv0 = n_fv;
            push_frame(vecs[i]);
            for (int k = 0; k < 4; k++) scan_pos(k, vecs[i].segs[8*k +: 8]);
            show(4'b1111, 8'hFF, 5);
            check("scan_one_frame", 32'(n_fv - fv0), 32'd1);
            check("scan_active",    32'(active),     32'd1);
            check("scan_hold",      32'(digits),     32'(vecs[i].digits));
        end
        check("scan_no_err", 32'(n_err), 32'd0);

        // Glitching position 0 shorter than SETTLE: must never be accepted
        v = vecs[0];
        fv0 = n_fv;
        for (int r = 0; r < 6; r++) begin
            show(4'b1110, 8'hFF, 3);
            show(4'b1110, 8'hC0, 3);
        end
        for (int k = 1; k < 4; k++) scan_pos(k, v.segs[8*k +: 8]);
        show(4'b1111, 8'hFF, 5);
        check("glitch_no_frame", 32'(n_fv - fv0), 32'd0);
        check("glitch_no_err",   32'(n_err),      32'd0);
        push_frame(v);
        scan_pos(0, v.segs[7:0]);
        show(4'b1111, 8'hFF, 3);
        check("glitch_late_frame", 32'(n_fv - fv0), 32'd1);

        // Illegal anode pattern and illegal segment code
        v = vecs[2];
        fv0 = n_fv;
        er0 = n_err;
        for (int k = 0; k < 3; k++) scan_pos(k, v.segs[8*k +: 8]);
        show(4'b1100, 8'hC0, 10);
        check("err_two_anodes", 32'(n_err - er0), 32'd1);
        scan_pos(3, v.segs[31:24]);
        show(4'b1111, 8'hFF, 5);
        check("err_seen_cleared", 32'(n_fv - fv0), 32'd0);
        scan_pos(1, 8'hAA);
        check("err_bad_code", 32'(n_err - er0), 32'd2);
        push_frame(v);
        for (int k = 0; k < 4; k++) scan_pos(k, v.segs[8*k +: 8]);
        show(4'b1111, 8'hFF, 5);
        check("err_recover_frame", 32'(n_fv - fv0), 32'd1);

        // Reset mid-frame discards the partial frame
        v = vecs[1];
        fv0 = n_fv;
        scan_pos(0, v.segs[7:0]);
        scan_pos(1, v.segs[15:8]);
        show(4'b1111, 8'hFF, 3);
        rst = 1'b1;
        show(4'b1111, 8'hFF, 1);
        rst = 1'b0;
        check_reset_outputs("midrst");
        scan_pos(2, v.segs[23:16]);
        scan_pos(3, v.segs[31:24]);
        show(4'b1111, 8'hFF, 5);
        check("midrst_no_frame", 32'(n_fv - fv0), 32'd0);
        check_reset_outputs("midrst_hold");
        push_frame(v);
        scan_pos(0, v.segs[7:0]);
        show(4'b1111, 8'hFF, 12);

        // Pin change to frame_valid latency: SETTLE+4 edges
        an_in  = 4'b1101;
        seg_in = v.segs[15:8];
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                lat = n;
                break;
            end
        end
        check("latency_edges", 32'(lat), 32'(SETTLE + 4));
        show(4'b1101, v.segs[15:8], 4);
        check("midrst_frame_count", 32'(n_fv - fv0), 32'd1);
        check("post_rst_active", 32'(active), 32'd1);

        // Inactivity timeout drops active but keeps the frame
        show(4'b1111, 8'hFF, TIMEOUT - 20);
        check("timeout_still_active", 32'(active), 32'd1);
        show(4'b1111, 8'hFF, 30);
        check("timeout_inactive", 32'(active), 32'd0);
        check("timeout_digits",   32'(digits), 32'(v.digits));
        check("timeout_blank",    32'(blank),  32'(v.blank));
        check("timeout_dp",       32'(dp),     32'(v.dp));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_err",     32'(n_err),        32'd2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
